aes_key_sched_ctrl: RTL
=======================

Name: aes_key_sched_ctrl

Overview:
Iterative AES-128 key-schedule controller. It replaces the fully unrolled key expansion with one round key generated per clock, using a single one-word SBytes instance (NWords = 1). Round keys 0..10 go into an internal 11 x 128-bit store and are served to the cipher rounds through a registered read port. It sits between the key-load interface and the encrypt/decrypt round datapath, and sequences expansion with a load handshake and busy/done status.

Parameters:
NK, 4, key length in 32-bit words; only 4 is supported (elaboration error otherwise)
NR, 10, number of rounds; only 10 is supported
RW, 4, width of the round index

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
key_in  in  128  cipher key; key_in[127:96] = w0 ... key_in[31:0] = w3
key_valid  in  1  key load request
key_ready  out  1  controller can accept a key
rd_en  in  1  round-key read request
rd_round  in  RW  round index to read, 0..10
rd_key  out  128  round key; w[4r] in [127:96]
rd_valid  out  1  rd_key holds a valid requested key
busy  out  1  expansion in progress
done  out  1  one-cycle pulse when round 10 is written
keys_ready  out  1  all 11 round keys valid

Behaviour:
- Reset (async, rst=1): state IDLE, key store and working words cleared, rcon=8'h01, avail=0. Output values: key_ready=1, rd_key=0, rd_valid=0, busy=0, done=0, keys_ready=0.
- States: IDLE and EXPAND.
- key_ready = (state==IDLE), combinational from state.
- Load happens at edge T0 with key_valid&key_ready:
  - store[0]=key_in; working words w0..w3 = key_in.
  - rcon=8'h01, cnt=1, avail=1.
  - keys_ready->0; state->EXPAND.
  - key_valid while busy is ignored (no queuing).
- EXPAND, each cycle with cnt=r:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2 (ripple chain inside one cycle).
  - At the edge: store[r]={n0,n1,n2,n3}; w<=n; avail<=r+1; cnt<=r+1.
  - rcon <= xtime(rcon): (rcon<<1) ^ (rcon[7] ? 8'h1b : 8'h00). Sequence 01,02,04,08,10,20,40,80,1b,36.
- Round r is written at edge Tr (r = 1..10). At T10: state->IDLE, done=1 for exactly one cycle, keys_ready=1 (held until the next load).
- busy = 1 from after T0 through the cycle before T10. Expansion latency is 10 cycles from load to done.
- Read port (1-cycle latency, registered):
  - If rd_en is sampled at edge E and rd_round < avail (as of before E), then after E: rd_key=store[rd_round], rd_valid=1.
  - Otherwise rd_valid=0 after E and rd_key holds its value.
  - rd_round > 10 always gives rd_valid=0.
  - Reads during EXPAND are legal for rounds already written.
- Simultaneous events:
  - If a read of round r coincides with the write of round r at edge Tr, rd_valid=0 (avail is not yet updated); the requester retries.
  - A load and a read at the same edge: the read is evaluated against the pre-load avail and store, so old keys are served.
- Reset mid-expansion: aborts immediately to reset values. No done pulse; partial keys are discarded.
- No combinational path from inputs to outputs except rst.

Test Plan:
- Reset, then load key 2b7e151628aed2a6abf7158809cf4f3c -> busy for 10 cycles; done pulses once at T10 with keys_ready=1. Reads return round1=a0fafe1788542cb123a339392a6c7605, round2=f2c295f27a96b9435935807a7359f67f, round10=d014f9a8c9ee2589e13f0cc8b6630ca6, round0=key.
- Read round 5 at T3 -> rd_valid=0. Read round 2 at T3 -> rd_valid=1 with the correct key. Read round 4 exactly at T4 -> rd_valid=0.
- key_valid held high with a different key during EXPAND -> ignored; final keys match the first key; key_ready=0 throughout.
- Assert rst at T5, then load key 000102030405060708090a0b0c0d0e0f -> no done from the aborted run; round10=13111d7fe3944a17f307a78b4d2b30c5.
- Back-to-back: load a second key the cycle after done -> keys_ready drops; reads of round 3 before T3' return rd_valid=0.
- rd_round=11..15 with rd_en=1 when keys_ready=1 -> rd_valid=0 and rd_key unchanged.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller.
// Expands one round key per clock through a single one-word SubWord path.
// Round keys 0..10 are kept in an 11-entry store and served through a
// one-cycle registered read port. Load handshake plus busy/done status.
module aes_key_sched_ctrl #(
    parameter int NK = 4,
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [127:0]  key_in,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic          rd_en,
    input  logic [RW-1:0] rd_round,
    output logic [127:0]  rd_key,
    output logic          rd_valid,
    output logic          busy,
    output logic          done,
    output logic          keys_ready
);

    // Only the AES-128 geometry is implemented.
    if (NK != 4) begin : g_nk_check
        $error("aes_key_sched_ctrl: only NK = 4 is supported");
    end
    if (NR != 10) begin : g_nr_check
        $error("aes_key_sched_ctrl: only NR = 10 is supported");
    end
    if (RW < 4) begin : g_rw_check
        $error("aes_key_sched_ctrl: RW must be at least 4");
    end

    localparam logic [RW-1:0] ROUND_ONE  = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_t;

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        logic [7:0] r;
        if (a[7]) begin
            r = {a[6:0], 1'b0} ^ 8'h1b;
        end else begin
            r = {a[6:0], 1'b0};
        end
        return r;
    endfunction

    // GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ aa;
            end else begin
                acc = acc;
            end
            aa = xtime(aa);
        end
        return acc;
    endfunction

    // AES S-box: multiplicative inverse (a^254, 0 maps to 0) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] pw;
        logic [7:0] inv;
        pw  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            pw  = gf_mul(pw, pw);
            inv = gf_mul(inv, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    state_t         r_state;
    state_t         w_state_nxt;
    logic [127:0]   r_store [0:NR];
    logic [31:0]    r_w0;
    logic [31:0]    r_w1;
    logic [31:0]    r_w2;
    logic [31:0]    r_w3;
    logic [7:0]     r_rcon;
    logic [RW-1:0]  r_cnt;
    logic [RW-1:0]  r_avail;
    logic           r_done;
    logic           r_keys_ready;
    logic [127:0]   r_rd_key;
    logic           r_rd_valid;

    logic           w_load;
    logic           w_last;
    logic           w_rd_hit;
    logic [31:0]    w_rot;
    logic [31:0]    w_t;
    logic [31:0]    w_n0;
    logic [31:0]    w_n1;
    logic [31:0]    w_n2;
    logic [31:0]    w_n3;

    assign key_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state == ST_EXPAND);
    assign done       = r_done;
    assign keys_ready = r_keys_ready;
    assign rd_key     = r_rd_key;
    assign rd_valid   = r_rd_valid;

    // Handshake decode: load only when idle, finish when round 10 is produced.
    always_comb begin
        w_load   = key_valid & (r_state == ST_IDLE);
        w_last   = (r_state == ST_EXPAND) & (r_cnt == LAST_ROUND);
        w_rd_hit = rd_en & (rd_round < r_avail);
    end

    // One key-expansion step: RotWord, SubWord, Rcon, then the word ripple chain.
    always_comb begin
        w_rot = {r_w3[23:0], r_w3[31:24]};
        w_t   = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                 sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {r_rcon, 24'h000000};
        w_n0  = r_w0 ^ w_t;
        w_n1  = r_w1 ^ w_n0;
        w_n2  = r_w2 ^ w_n1;
        w_n3  = r_w3 ^ w_n2;
    end

    // Next-state logic for the IDLE/EXPAND controller.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_EXPAND;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXPAND: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_EXPAND;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Key store, working words, round counter and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) begin
                r_store[i] <= 128'h0;
            end
            r_w0         <= 32'h0;
            r_w1         <= 32'h0;
            r_w2         <= 32'h0;
            r_w3         <= 32'h0;
            r_rcon       <= 8'h01;
            r_cnt        <= '0;
            r_avail      <= '0;
            r_done       <= 1'b0;
            r_keys_ready <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_store[0]   <= key_in;
                r_w0         <= key_in[127:96];
                r_w1         <= key_in[95:64];
                r_w2         <= key_in[63:32];
                r_w3         <= key_in[31:0];
                r_rcon       <= 8'h01;
                r_cnt        <= ROUND_ONE;
                r_avail      <= ROUND_ONE;
                r_keys_ready <= 1'b0;
            end else if (r_state == ST_EXPAND) begin
                r_store[r_cnt] <= {w_n0, w_n1, w_n2, w_n3};
                r_w0           <= w_n0;
                r_w1           <= w_n1;
                r_w2           <= w_n2;
                r_w3           <= w_n3;
                r_rcon         <= xtime(r_rcon);
                r_cnt          <= r_cnt + ROUND_ONE;
                r_avail        <= r_cnt + ROUND_ONE;
                if (w_last) begin
                    r_done       <= 1'b1;
                    r_keys_ready <= 1'b1;
                end else begin
                    r_keys_ready <= r_keys_ready;
                end
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Registered read port; a round is readable only once it has been written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_key   <= 128'h0;
            r_rd_valid <= 1'b0;
        end else if (w_rd_hit) begin
            r_rd_key   <= r_store[rd_round];
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

endmodule
